rv32_exec_unit: RTL and testbench
=================================

Name: rv32_exec_unit

Overview:
- Execute/writeback stage for the RV32I SOC core.
- Consumes the fetched instruction, PC and register operands rs1/rs2 that the fetch/register-read state machine produces.
- Returns the register writeback (data, enable, rd), the next PC, and the effective address for load/store.
- Shifts run on an optional serial shifter, one bit per cycle, to save LUTs on the small FPGA; every other operation completes in one cycle.

Parameters:
- SERIAL_SHIFT, 1, 1 = serial shifter (1 bit per clk); 0 = single-cycle barrel shift.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: instr/pc/rs1/rs2 are valid, begin execution
- instr  in  32  instruction word
- pc  in  32  byte address of instr
- rs1  in  32  register operand 1
- rs2  in  32  register operand 2
- busy  out  1  operation in progress; start is ignored while high
- done  out  1  one-cycle pulse: all result outputs valid this cycle
- wb_en  out  1  write wb_data to register wb_rd
- wb_rd  out  5  destination register index
- wb_data  out  32  writeback value
- next_pc  out  32  PC of the next instruction
- mem_addr  out  32  rs1+Iimm for LOAD, rs1+Simm for STORE, else 0
- halt  out  1  held high after SYSTEM executes, until reset

Behaviour:
- Reset: clk and resetn are the only clock/reset. resetn is asynchronous, active-low. While low, every output is 0, the FSM is in IDLE, and the shift counter is 0. Reset asserted mid-shift aborts the operation; no done is produced.
- FSM states:
  - IDLE: on start, latch operands. Non-shift ops, or shift with shamt=0, or SERIAL_SHIFT=0 → go to DONE. Serial shift with shamt>0 → go to SHIFT.
  - SHIFT: shift 1 bit per cycle and decrement the counter; when the counter reaches 0, go to DONE.
  - DONE: assert done for exactly one cycle, then return to IDLE.
- busy = (state != IDLE).
- Latency (start sampled in cycle t): done in t+1 for non-shift ops; done in t+1+shamt for serial shifts.
- shamt source: rs2[4:0] for ALUreg, instr[24:20] for ALUimm.
- Result outputs are registered and hold their value until the next done; they are not cleared on return to IDLE.
- start during busy: ignored, no effect on the operation in flight.
- ALU, selected by funct3, operand 2 = rs2 (ALUreg) or Iimm (ALUimm):
  - ADD/SUB: SUB only when ALUreg and instr[30]=1; ADDI never subtracts.
  - SLL.
  - SLT signed, SLTU unsigned; result is 0 or 1.
  - XOR, OR, AND.
  - SRL/SRA: instr[30] selects arithmetic, for both reg and imm forms.
- Arithmetic is 32-bit modulo 2^32 with no overflow flag. SRA fills with the latched rs1[31].
- Immediate and PC rules:
  - LUI: wb_data = Uimm.
  - AUIPC: wb_data = pc+Uimm.
  - JAL: wb_data = pc+4, next_pc = pc+Jimm.
  - JALR: wb_data = pc+4, next_pc = (rs1+Iimm) & ~1.
  - Branch, funct3 000 BEQ / 001 BNE / 100 BLT / 101 BGE / 110 BLTU / 111 BGEU: taken → next_pc = pc+Bimm, else pc+4. wb_en = 0.
  - LOAD/STORE: wb_en = 0, next_pc = pc+4, mem_addr valid at done. The SOC performs the access.
  - SYSTEM: next_pc = pc, wb_en = 0, halt set at done.
  - Any other opcode: treated as NOP (next_pc = pc+4, wb_en = 0).
- Writeback gating: wb_en = 1 only at done, only for ALUreg/ALUimm/LUI/AUIPC/JAL/JALR, and only when rd != 0. wb_rd = instr[11:7] always. wb_en is low outside done.
- Wrap: pc+4 from 0xFFFFFFFC gives 0x00000000; no trap.

Decomposition:
- Shared package rv32_pkg: opcode localparams (ALUREG, ALUIMM, BRANCH, JALR, JAL, AUIPC, LUI, LOAD, STORE, SYSTEM), funct3 codes, FSM state encoding (IDLE, SHIFT, DONE), NOP encoding 0x00000033.
- The five immediate-decode functions (I/S/B/U/J) also live in rv32_pkg so the decode stage shares them.
- One sub-module: rv32_serial_shifter (load / shift-enable / dir / arith, 5-bit counter, count_zero flag); bypassed when SERIAL_SHIFT=0.

Test Plan:
- ALUimm: addi x1,x0,5 (0x00500093), rs1=0, pc=0x10 → done at t+1, wb_en=1, wb_rd=1, wb_data=5, next_pc=0x14.
- SRA: sra x3,x1,x2 with rs1=0x80000000, rs2=4 → done at t+5, wb_data=0xF8000000, busy high t+1..t+4; a start pulse at t+2 is ignored.
- Branch: bne, rs1=1, rs2=2, pc=0x20, Bimm=-8 → next_pc=0x18, wb_en=0; same with rs1=rs2=2 → next_pc=0x24.
- JALR: rs1=0x101, Iimm=0, pc=0x40, rd=1 → next_pc=0x100, wb_data=0x44.
- rd=x0 write, and SLTU 0xFFFFFFFF vs 1:
  - add x0,x1,x1 → done pulses, wb_en=0.
  - sltu x5 (rs1=0xFFFFFFFF, rs2=1) → wb_data=0.
  - slt, same operands → wb_data=1.
- Reset and SYSTEM:
  - resetn low at t+2 during a shamt=10 shift → all outputs 0 immediately; after release, busy=0 and no done pulse.
  - ebreak (0x00100073), pc=0x1C → next_pc=0x1C, halt=1 and held.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, funct3 codes, exec FSM states and immediate decoders shared by the RV32I core
package rv32_pkg;
  localparam logic [6:0] ALUREG = 7'b0110011;
  localparam logic [6:0] ALUIMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [31:0] NOP = 32'h00000033;
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/rv32_serial_shifter.sv
// rv32_serial_shifter: one-bit-per-cycle shifter; dout/count_zero report the value after this cycle's step
module rv32_serial_shifter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        en,
  input  logic        dir,
  input  logic        arith,
  input  logic [4:0]  shamt,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        count_zero
);
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        step;
  always_comb begin
    step = en && cnt_q != 5'd0;
    data_d = load ? din : step ? (dir ? {arith & data_q[31], data_q[31:1]} : {data_q[30:0], 1'b0}) : data_q;
    cnt_d = load ? shamt : step ? cnt_q - 5'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout = data_d;
  assign count_zero = cnt_d == 5'd0;
endmodule

// File: rtl/rv32_exec_unit.sv
// rv32_exec_unit: RV32I execute/writeback stage with optional serial shifter
module rv32_exec_unit
  import rv32_pkg::*;
#(
  parameter int SERIAL_SHIFT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] next_pc,
  output logic [31:0] mem_addr,
  output logic        halt
);
  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic        done_q, done_d, wb_en_q, wb_en_d, halt_q, halt_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d, next_pc_q, next_pc_d, mem_addr_q, mem_addr_d;
  logic        is_idle, accept, is_alu, is_shift, serial_go, sh_zero, taken, wr, fin;
  logic [31:0] i, p, a, b, op2, sh_dout, sra, barrel, sh_res, alu_res, pc4, wb_val, npc, maddr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  shamt;
  always_comb begin
    is_idle = state_q == S_IDLE;
    accept = is_idle && start;
    i = is_idle ? instr : instr_q;
    p = is_idle ? pc : pc_q;
    a = is_idle ? rs1 : rs1_q;
    b = is_idle ? rs2 : rs2_q;
    op = i[6:0];
    f3 = i[14:12];
    is_alu = op == ALUREG || op == ALUIMM;
    op2 = op == ALUREG ? b : imm_i(i);
    shamt = op2[4:0];
    is_shift = is_alu && (f3 == F3_SLL || f3 == F3_SR);
    serial_go = SERIAL_SHIFT != 0 && is_shift && shamt != 5'd0;
  end
  rv32_serial_shifter u_shifter (
    .clk(clk),
    .resetn(resetn),
    .load(accept && serial_go),
    .en(state_q == S_SHIFT),
    .dir(f3 == F3_SR),
    .arith(i[30]),
    .shamt(shamt),
    .din(a),
    .dout(sh_dout),
    .count_zero(sh_zero)
  );
  always_comb begin
    sra = $signed(a) >>> shamt;
    barrel = f3 == F3_SLL ? a << shamt : i[30] ? sra : a >> shamt;
    sh_res = SERIAL_SHIFT == 0 ? barrel : state_q == S_SHIFT ? sh_dout : a;
    alu_res = f3 == F3_ADD ? ((op == ALUREG && i[30]) ? a - op2 : a + op2) :
              is_shift ? sh_res :
              f3 == F3_SLT ? {31'b0, $signed(a) < $signed(op2)} :
              f3 == F3_SLTU ? {31'b0, a < op2} :
              f3 == F3_XOR ? a ^ op2 :
              f3 == F3_OR ? a | op2 : a & op2;
    taken = f3[2] ? ((f3[1] ? a < b : $signed(a) < $signed(b)) ^ f3[0]) : ((a == b) ^ f3[0]);
    pc4 = p + 32'd4;
    wb_val = op == LUI ? imm_u(i) : op == AUIPC ? p + imm_u(i) : (op == JAL || op == JALR) ? pc4 : alu_res;
    npc = op == JAL ? p + imm_j(i) :
          op == JALR ? (a + imm_i(i)) & ~32'd1 :
          op == BRANCH ? (taken ? p + imm_b(i) : pc4) :
          op == SYSTEM ? p : pc4;
    maddr = op == LOAD ? a + imm_i(i) : op == STORE ? a + imm_s(i) : 32'd0;
    wr = (is_alu || op == LUI || op == AUIPC || op == JAL || op == JALR) && i[11:7] != 5'd0;
    state_d = accept ? (serial_go ? S_SHIFT : S_DONE) :
              state_q == S_SHIFT ? (sh_zero ? S_DONE : S_SHIFT) :
              state_q == S_DONE ? S_IDLE : state_q;
    fin = state_d == S_DONE;
    instr_d = accept ? instr : instr_q;
    pc_d = accept ? pc : pc_q;
    rs1_d = accept ? rs1 : rs1_q;
    rs2_d = accept ? rs2 : rs2_q;
    done_d = fin;
    wb_en_d = fin && wr;
    wb_rd_d = fin ? i[11:7] : wb_rd_q;
    wb_data_d = fin ? wb_val : wb_data_q;
    next_pc_d = fin ? npc : next_pc_q;
    mem_addr_d = fin ? maddr : mem_addr_q;
    halt_d = halt_q || (fin && op == SYSTEM);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      instr_q    <= NOP;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      done_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      next_pc_q  <= '0;
      mem_addr_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      done_q     <= done_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      next_pc_q  <= next_pc_d;
      mem_addr_q <= mem_addr_d;
      halt_q     <= halt_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign wb_en = wb_en_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign next_pc = next_pc_q;
  assign mem_addr = mem_addr_q;
  assign halt = halt_q;
endmodule

// File: tb/tb_rv32_exec_unit.sv
// tb_rv32_exec_unit: directed and random instructions checked against an instruction-level model
module tb_rv32_exec_unit;
  logic        clk, resetn, start;
  logic [31:0] instr, pc, rs1, rs2;
  logic        busy, done, wb_en, halt;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, next_pc, mem_addr;
  int checks = 0;
  int errors = 0;
  logic halted;
  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic [31:0] npc;
    logic [31:0] maddr;
    logic        sys;
    int          lat;
  } exp_t;
  rv32_exec_unit dut (
    .clk(clk), .resetn(resetn), .start(start), .instr(instr), .pc(pc), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .next_pc(next_pc), .mem_addr(mem_addr), .halt(halt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] ii, si, bi, ui, ji, o2;
    logic t;
    int sh;
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ui = {ins[31:12], 12'h000};
    ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e.wr = 1'b0; e.data = 32'd0; e.npc = p + 32'd4; e.maddr = 32'd0; e.sys = 1'b0; e.lat = 1;
    case (ins[6:0])
      7'h33, 7'h13: begin
        e.wr = 1'b1;
        o2 = ins[5] ? b : ii;
        sh = int'(o2[4:0]);
        case (ins[14:12])
          3'd0: e.data = (ins[5] && ins[30]) ? a - o2 : a + o2;
          3'd1: e.data = a << sh;
          3'd2: e.data = ((a ^ 32'h80000000) < (o2 ^ 32'h80000000)) ? 32'd1 : 32'd0;
          3'd3: e.data = (a < o2) ? 32'd1 : 32'd0;
          3'd4: e.data = a ^ o2;
          3'd5: e.data = (a >> sh) | ((ins[30] && a[31]) ? ~(32'hFFFFFFFF >> sh) : 32'h0);
          3'd6: e.data = a | o2;
          default: e.data = a & o2;
        endcase
        if ((ins[14:12] == 3'd1 || ins[14:12] == 3'd5) && sh > 0) e.lat = 1 + sh;
      end
      7'h37: begin e.wr = 1'b1; e.data = ui; end
      7'h17: begin e.wr = 1'b1; e.data = p + ui; end
      7'h6f: begin e.wr = 1'b1; e.data = p + 32'd4; e.npc = p + ji; end
      7'h67: begin e.wr = 1'b1; e.data = p + 32'd4; e.npc = (a + ii) & 32'hFFFFFFFE; end
      7'h63: begin
        case (ins[14:12])
          3'd0: t = a == b;
          3'd1: t = a != b;
          3'd4: t = (a ^ 32'h80000000) < (b ^ 32'h80000000);
          3'd5: t = !((a ^ 32'h80000000) < (b ^ 32'h80000000));
          3'd6: t = a < b;
          default: t = !(a < b);
        endcase
        if (t) e.npc = p + bi;
      end
      7'h03: e.maddr = a + ii;
      7'h23: e.maddr = a + si;
      7'h73: begin e.npc = p; e.sys = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction
  task automatic check_idle(input string tag);
    check({tag, ".done"}, {31'b0, done}, 32'd0);
    check({tag, ".busy"}, {31'b0, busy}, 32'd0);
    check({tag, ".wb_en"}, {31'b0, wb_en}, 32'd0);
    check({tag, ".wb_rd"}, {27'b0, wb_rd}, 32'd0);
    check({tag, ".wb_data"}, wb_data, 32'd0);
    check({tag, ".next_pc"}, next_pc, 32'd0);
    check({tag, ".mem_addr"}, mem_addr, 32'd0);
    check({tag, ".halt"}, {31'b0, halt}, 32'd0);
  endtask
  task automatic run_op(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b, input int poke);
    exp_t e;
    int k;
    e = model(ins, p, a, b);
    if (e.sys) halted = 1'b1;
    instr = ins; pc = p; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; instr = $urandom; pc = $urandom; rs1 = $urandom; rs2 = $urandom;
    k = 1;
    while (!done && k < 64) begin
      check("busy_in_flight", {31'b0, busy}, 32'd1);
      if (k == poke) begin
        start = 1'b1;
        instr = 32'h00700393;
      end else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("latency", k, e.lat);
    check("busy_at_done", {31'b0, busy}, 32'd1);
    check("wb_en", {31'b0, wb_en}, {31'b0, e.wr && ins[11:7] != 5'd0});
    check("wb_rd", {27'b0, wb_rd}, {27'b0, ins[11:7]});
    if (e.wr) check("wb_data", wb_data, e.data);
    check("next_pc", next_pc, e.npc);
    check("mem_addr", mem_addr, e.maddr);
    check("halt", {31'b0, halt}, {31'b0, halted});
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("wb_en_after", {31'b0, wb_en}, 32'd0);
    check("busy_after", {31'b0, busy}, 32'd0);
  endtask
  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73};
  initial begin
    logic [31:0] ins, a;
    logic seen_done, seen_busy;
    int sel;
    resetn = 1'b0; start = 1'b0; instr = 32'd0; pc = 32'd0; rs1 = 32'd0; rs2 = 32'd0; halted = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    resetn = 1'b1;
    @(negedge clk);
    run_op(32'h00500093, 32'h10, 32'd0, $urandom, 0);
    run_op(32'h4020D1B3, 32'h80, 32'h80000000, 32'd4, 1);
    run_op(32'hFE209CE3, 32'h20, 32'd1, 32'd2, 0);
    run_op(32'hFE209CE3, 32'h20, 32'd2, 32'd2, 0);
    run_op(32'h000100E7, 32'h40, 32'h101, 32'd0, 0);
    run_op(32'h00108033, 32'h50, 32'h1234, 32'h1234, 0);
    run_op(32'h0020B2B3, 32'h54, 32'hFFFFFFFF, 32'd1, 0);
    run_op(32'h0020A2B3, 32'h58, 32'hFFFFFFFF, 32'd1, 0);
    run_op(32'h00500093, 32'hFFFFFFFC, 32'd7, 32'd0, 0);
    instr = 32'h00209233; pc = 32'h60; rs1 = $urandom | 32'd1; rs2 = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    halted = 1'b0;
    #1;
    check_idle("mid_shift_reset");
    @(negedge clk);
    resetn = 1'b1;
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    check("aborted_done", {31'b0, seen_done}, 32'd0);
    check("aborted_busy", {31'b0, seen_busy}, 32'd0);
    run_op(32'h00100073, 32'h1C, $urandom, $urandom, 0);
    run_op(32'h00500093, 32'h20, 32'd0, 32'd0, 0);
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 10) ins[6:0] = ops[sel];
      if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14:12] = 3'b000;
      a = $urandom;
      run_op(ins, $urandom, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
